// File: rtl/trigger_seq_pkg.sv
// Shared types and constants for the trigger sweep sequencer.
// Holds the FSM state encoding, fault codes and the table entry layout.
// The fine-delay clamp and the rest-state test live here so top and bench agree.
package trigger_seq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_LOAD    = 3'd1,
    ST_SETTLE  = 3'd2,
    ST_ARMED   = 3'd3,
    ST_ADVANCE = 3'd4,
    ST_DONE    = 3'd5,
    ST_FAULT   = 3'd6
  } state_t;

  // Largest fine delay the MMCM phase shifter can realise.
  localparam logic [15:0] FINE_MAX_PS = 16'd9999;

  localparam logic [1:0] FAULT_NONE         = 2'd0;
  localparam logic [1:0] FAULT_BAD_LEN      = 2'd1;
  localparam logic [1:0] FAULT_LOCK_TIMEOUT = 2'd2;

  // One sweep step: coarse delay in clock cycles, fine delay in picoseconds.
  typedef struct packed {
    logic [31:0] coarse;
    logic [15:0] fine;
  } tbl_entry_t;

  // Clamp a programmed fine delay to what the MMCM can do.
  function automatic logic [15:0] sat_fine(input logic [15:0] ps);
    return (ps > FINE_MAX_PS) ? FINE_MAX_PS : ps;
  endfunction

  // States in which the sequencer is at rest: table writable, arm accepted.
  function automatic logic is_rest(input state_t s);
    return (s == ST_IDLE) || (s == ST_DONE) || (s == ST_FAULT);
  endfunction

endpackage

// File: rtl/trigger_seq_table.sv
// Delay table: DEPTH entries of (coarse, fine), one write port, one read port.
// Read data follows rd_addr combinationally; the caller keeps rd_addr registered.
// Storage has no reset so a programmed table survives a sequencer reset.
module trigger_seq_table
  import trigger_seq_pkg::*;
#(
  parameter int DEPTH  = 16,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] wr_addr,
  input  tbl_entry_t        wr_data,
  input  logic [ADDR_W-1:0] rd_addr,
  output tbl_entry_t        rd_data
);

  tbl_entry_t mem [DEPTH];

  // Single write port; contents only change on an accepted host write.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[wr_addr] <= wr_data;
    end
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/trigger_sweep_sequencer.sv
// Steps the trigger delay datapath through a table of (coarse, fine) delays, one shot per entry.
// Update strobes one cycle after arm/advance; trigger enabled SETTLE_CYCLES+2 cycles after that.
// abort wins over everything; table writes are dropped unless the sequencer is at rest.
module trigger_sweep_sequencer
  import trigger_seq_pkg::*;
#(
  parameter int DEPTH         = 16,
  parameter int SETTLE_CYCLES = 64,
  parameter int LOCK_TIMEOUT  = 65536,
  parameter int ADDR_W        = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              tbl_we,
  input  logic [ADDR_W-1:0] tbl_addr,
  input  logic [31:0]       tbl_coarse,
  input  logic [15:0]       tbl_fine,
  input  logic [ADDR_W:0]   tbl_len,
  input  logic              loop_en,
  input  logic              arm,
  input  logic              abort,
  input  logic              trig_fired,
  input  logic              mmcm_locked,
  output logic [31:0]       coarse_delay,
  output logic              coarse_update,
  output logic [15:0]       fine_delay_ps,
  output logic              fine_update,
  output logic              trig_enable,
  output logic              busy,
  output logic              done,
  output logic              fault,
  output logic [1:0]        fault_code,
  output logic [ADDR_W-1:0] cur_index,
  output logic [31:0]       shot_count
);

  localparam int SW = $clog2(SETTLE_CYCLES + 1);
  localparam int TW = $clog2(LOCK_TIMEOUT + 1);

  state_t            state;
  state_t            state_next;
  logic              trig_prev;
  logic              trig_rise;
  logic              arm_evt;
  logic              len_ok;
  logic [ADDR_W:0]   idx_inc;
  logic              idx_last;
  logic [ADDR_W-1:0] idx_next;
  logic [ADDR_W-1:0] rd_addr;
  tbl_entry_t        rd_data;
  tbl_entry_t        wr_data;
  logic              tbl_wr;
  logic [SW-1:0]     settle_cnt;
  logic [TW-1:0]     tmo_cnt;
  logic              settle_hit;
  logic              tmo_hit;

  assign trig_rise = trig_fired & ~trig_prev;
  assign arm_evt   = is_rest(state) & arm & ~abort;
  assign len_ok    = (tbl_len != '0) && (tbl_len <= (ADDR_W + 1)'(DEPTH));

  // Live tbl_len is compared with >= so a shrunken length still terminates or wraps.
  assign idx_inc  = {1'b0, cur_index} + 1'b1;
  assign idx_last = (idx_inc >= tbl_len);
  assign idx_next = idx_last ? '0 : idx_inc[ADDR_W-1:0];

  assign settle_hit = mmcm_locked && (settle_cnt == SW'(SETTLE_CYCLES - 1));
  assign tmo_hit    = (tmo_cnt == TW'(LOCK_TIMEOUT - 1));

  assign tbl_wr  = tbl_we & is_rest(state);
  assign wr_data = '{coarse: tbl_coarse, fine: tbl_fine};

  trigger_seq_table #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_table (
    .clk     (clk),
    .we      (tbl_wr),
    .wr_addr (tbl_addr),
    .wr_data (wr_data),
    .rd_addr (rd_addr),
    .rd_data (rd_data)
  );

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state decode; abort overrides every other transition, including arm.
  always_comb begin
    state_next = state;
    if (abort) begin
      state_next = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE, ST_DONE, ST_FAULT: begin
          if (arm) begin
            state_next = len_ok ? ST_LOAD : ST_FAULT;
          end
        end
        ST_LOAD: begin
          state_next = ST_SETTLE;
        end
        ST_SETTLE: begin
          if (settle_hit) begin
            state_next = ST_ARMED;
          end else if (tmo_hit) begin
            state_next = ST_FAULT;
          end
        end
        ST_ARMED: begin
          if (trig_rise) begin
            state_next = ST_ADVANCE;
          end
        end
        ST_ADVANCE: begin
          state_next = (idx_last && !loop_en) ? ST_DONE : ST_LOAD;
        end
        default: begin
          state_next = ST_IDLE;
        end
      endcase
    end
  end

  // Trigger edge history runs in every state so a level already high entering ARMED is not a shot.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      trig_prev <= 1'b0;
    end else begin
      trig_prev <= trig_fired;
    end
  end

  // Lock-settle and timeout counters, both live only while in SETTLE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      settle_cnt <= '0;
      tmo_cnt    <= '0;
    end else if (state == ST_SETTLE && state_next == ST_SETTLE) begin
      settle_cnt <= mmcm_locked ? settle_cnt + 1'b1 : '0;
      tmo_cnt    <= tmo_cnt + 1'b1;
    end else begin
      settle_cnt <= '0;
      tmo_cnt    <= '0;
    end
  end

  // Look-ahead read address: entry 0 while at rest, the following entry while ARMED.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_addr <= '0;
    end else if (is_rest(state_next)) begin
      rd_addr <= '0;
    end else if (state == ST_ARMED) begin
      rd_addr <= idx_next;
    end
  end

  // Registered outputs, decoded from the next state so they line up with it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      coarse_delay  <= '0;
      coarse_update <= 1'b0;
      fine_delay_ps <= '0;
      fine_update   <= 1'b0;
      trig_enable   <= 1'b0;
      busy          <= 1'b0;
      done          <= 1'b0;
      fault         <= 1'b0;
      fault_code    <= FAULT_NONE;
      cur_index     <= '0;
      shot_count    <= '0;
    end else begin
      trig_enable   <= (state_next == ST_ARMED);
      busy          <= !is_rest(state_next);
      coarse_update <= (state_next == ST_LOAD);
      fine_update   <= (state_next == ST_LOAD);

      if (state_next == ST_LOAD) begin
        coarse_delay  <= rd_data.coarse;
        fine_delay_ps <= sat_fine(rd_data.fine);
        cur_index     <= rd_addr;
      end

      if (arm_evt && len_ok) begin
        shot_count <= '0;
        done       <= 1'b0;
        fault      <= 1'b0;
        fault_code <= FAULT_NONE;
      end else if (arm_evt) begin
        done       <= 1'b0;
        fault      <= 1'b1;
        fault_code <= FAULT_BAD_LEN;
      end else begin
        if (state == ST_SETTLE && state_next == ST_FAULT) begin
          fault      <= 1'b1;
          fault_code <= FAULT_LOCK_TIMEOUT;
        end
        if (state == ST_ADVANCE && state_next == ST_DONE) begin
          done <= 1'b1;
        end
        if (state == ST_ARMED && state_next == ST_ADVANCE && shot_count != '1) begin
          shot_count <= shot_count + 32'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_trigger_sweep_sequencer.sv
// Randomized bench for trigger_sweep_sequencer against a table-level reference model.
// Small DEPTH/SETTLE/TIMEOUT keep every scenario short.
// Inputs change 1 time unit after the rising edge; outputs are read there or on the falling edge.
module tb_trigger_sweep_sequencer;

  localparam int DEPTH  = 4;
  localparam int SETTLE = 8;
  localparam int TMO    = 100;
  localparam int AW     = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          tbl_we = 1'b0;
  logic [AW-1:0] tbl_addr = '0;
  logic [31:0]   tbl_coarse = '0;
  logic [15:0]   tbl_fine = '0;
  logic [AW:0]   tbl_len = '0;
  logic          loop_en = 1'b0;
  logic          arm = 1'b0;
  logic          abort = 1'b0;
  logic          trig_fired = 1'b0;
  logic          mmcm_locked = 1'b0;
  logic [31:0]   coarse_delay;
  logic          coarse_update;
  logic [15:0]   fine_delay_ps;
  logic          fine_update;
  logic          trig_enable;
  logic          busy;
  logic          done;
  logic          fault;
  logic [1:0]    fault_code;
  logic [AW-1:0] cur_index;
  logic [31:0]   shot_count;

  int checks = 0;
  int errors = 0;

  // Reference model: what software believes is in the table.
  int model_coarse [DEPTH];
  int model_fine   [DEPTH];
  logic [31:0] strobe_q [$];

  trigger_sweep_sequencer #(
    .DEPTH         (DEPTH),
    .SETTLE_CYCLES (SETTLE),
    .LOCK_TIMEOUT  (TMO)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .tbl_we        (tbl_we),
    .tbl_addr      (tbl_addr),
    .tbl_coarse    (tbl_coarse),
    .tbl_fine      (tbl_fine),
    .tbl_len       (tbl_len),
    .loop_en       (loop_en),
    .arm           (arm),
    .abort         (abort),
    .trig_fired    (trig_fired),
    .mmcm_locked   (mmcm_locked),
    .coarse_delay  (coarse_delay),
    .coarse_update (coarse_update),
    .fine_delay_ps (fine_delay_ps),
    .fine_update   (fine_update),
    .trig_enable   (trig_enable),
    .busy          (busy),
    .done          (done),
    .fault         (fault),
    .fault_code    (fault_code),
    .cur_index     (cur_index),
    .shot_count    (shot_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int exp_fine(input int f);
    return (f > 9999) ? 9999 : f;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Record every load strobe; coarse and fine strobes must always come as a pair.
  always @(negedge clk) begin
    if (!rst && (coarse_update || fine_update)) begin
      check("strobe_pair", {coarse_update, fine_update}, 2'b11);
      if (coarse_update) strobe_q.push_back(coarse_delay);
    end
  end

  task automatic write_entry(input int a, input int c, input int f, input bit accepted);
    tbl_addr   = AW'(a);
    tbl_coarse = 32'(c);
    tbl_fine   = 16'(f);
    tbl_we     = 1'b1;
    tick();
    tbl_we     = 1'b0;
    if (accepted) begin
      model_coarse[a] = c;
      model_fine[a]   = f;
    end
  endtask

  task automatic wait_enable(input int budget, output int k);
    k = 0;
    while (!trig_enable && k < budget) begin
      tick();
      k++;
    end
    check("enable_reached", trig_enable, 1'b1);
  endtask

  task automatic fire();
    repeat ($urandom_range(0, 2)) tick();
    trig_fired = 1'b1;
    tick();
    check("enable_drop", trig_enable, 1'b0);
    trig_fired = 1'b0;
  endtask

  // Arm and run nshots; entry for shot s is s mod len.
  task automatic run_sweep(input int len, input bit lp, input int nshots, input bit poke);
    int k;
    tbl_len     = (AW + 1)'(len);
    loop_en     = lp;
    mmcm_locked = 1'b1;
    strobe_q.delete();
    arm = 1'b1;
    tick();
    arm = 1'b0;
    check("load_strobe", coarse_update, 1'b1);
    check("first_coarse", coarse_delay, 64'(model_coarse[0]));
    check("arm_clears_fault", fault, 1'b0);
    wait_enable(SETTLE + 20, k);
    check("arm_to_enable", k + 1, SETTLE + 2);
    for (int s = 0; s < nshots; s++) begin
      int idx;
      idx = s % len;
      if (s > 0) begin
        wait_enable(SETTLE + 20, k);
        check("reload_to_enable", k, SETTLE + 2);
      end
      check("cur_index", cur_index, idx);
      check("coarse", coarse_delay, 64'(model_coarse[idx]));
      check("fine", fine_delay_ps, 64'(exp_fine(model_fine[idx])));
      check("shot_count_pre", shot_count, s);
      if (poke && s == 0) begin
        write_entry(0, 32'h0000DEAD, 1234, 1'b0);
        write_entry(1, 32'h0000BEEF, 4321, 1'b0);
      end
      fire();
    end
    if (!lp && nshots == len) begin
      tick();
      check("done", done, 1'b1);
      check("busy_after_done", busy, 1'b0);
      check("shot_count_final", shot_count, len);
      check("strobe_count", strobe_q.size(), len);
      for (int i = 0; i < len; i++) begin
        check("strobe_seq", strobe_q[i], 64'(model_coarse[i]));
      end
    end
  endtask

  initial begin
    int k;
    int j;
    int bad;
    bit en_seen;

    // Reset state.
    repeat (3) tick();
    check("rst_data", {coarse_delay, fine_delay_ps}, 64'd0);
    check("rst_ctl", {coarse_update, fine_update, trig_enable, busy, done, fault,
                      fault_code, cur_index, shot_count}, 64'd0);
    rst = 1'b0;
    tick();

    // Directed table including a fine value above the clamp.
    write_entry(0, 10, 0, 1'b1);
    write_entry(1, 20, 2500, 1'b1);
    write_entry(2, 30, 9999, 1'b1);
    write_entry(3, 40, 12000, 1'b1);
    run_sweep(4, 1'b0, 4, 1'b0);
    check("fine_saturated", fine_delay_ps, 16'd9999);

    // Looping sweep, writes while ARMED must be dropped, then abort while ARMED.
    run_sweep(2, 1'b1, 5, 1'b1);
    wait_enable(SETTLE + 20, k);
    check("loop_index", cur_index, 1);
    check("loop_shots", shot_count, 5);
    check("loop_not_done", done, 1'b0);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("abort_enable", trig_enable, 1'b0);
    check("abort_busy", busy, 1'b0);
    check("abort_coarse_hold", coarse_delay, 64'(model_coarse[1]));

    // Lock never comes: timeout fault, trigger never enabled.
    mmcm_locked = 1'b0;
    tbl_len = 3'd4;
    loop_en = 1'b0;
    arm = 1'b1;
    tick();
    arm = 1'b0;
    k = 1;
    en_seen = 1'b0;
    while (!fault && k < TMO + 20) begin
      tick();
      k++;
      if (trig_enable) en_seen = 1'b1;
    end
    check("timeout_cycles", k, TMO + 2);
    check("timeout_code", fault_code, 2);
    check("timeout_no_enable", en_seen, 1'b0);
    check("timeout_busy", busy, 1'b0);

    // One-cycle lock drop restarts the settle count.
    j = $urandom_range(3, SETTLE);
    mmcm_locked = 1'b1;
    arm = 1'b1;
    tick();
    arm = 1'b0;
    k = 1;
    check("rearm_fault_clear", {fault, fault_code}, 3'd0);
    while (!trig_enable && k < 3 * SETTLE + 10) begin
      tick();
      k++;
      mmcm_locked = (k == j) ? 1'b0 : 1'b1;
    end
    check("glitch_enable_cycle", k, j + SETTLE + 1);
    abort = 1'b1;
    tick();
    abort = 1'b0;

    // Invalid length faults immediately; a valid rearm clears it.
    bad = ($urandom_range(0, 1) == 0) ? 0 : $urandom_range(5, 7);
    tbl_len = (AW + 1)'(bad);
    arm = 1'b1;
    tick();
    arm = 1'b0;
    check("badlen_fault", fault, 1'b1);
    check("badlen_code", fault_code, 1);
    check("badlen_busy", busy, 1'b0);
    run_sweep(2, 1'b0, 2, 1'b0);
    check("rearm_code", fault_code, 0);

    // Asynchronous reset while settling.
    tbl_len = 3'd4;
    arm = 1'b1;
    tick();
    arm = 1'b0;
    tick();
    tick();
    #2 rst = 1'b1;
    #1;
    check("arst_data", {coarse_delay, fine_delay_ps}, 64'd0);
    check("arst_ctl", {coarse_update, fine_update, trig_enable, busy, done, fault,
                       fault_code, cur_index, shot_count}, 64'd0);
    tick();
    rst = 1'b0;
    tick();
    run_sweep(1, 1'b0, 1, 1'b0);

    // Random tables and lengths.
    for (int r = 0; r < 3; r++) begin
      for (int a = 0; a < DEPTH; a++) begin
        write_entry(a, $urandom_range(1, 100000), $urandom_range(0, 65535), 1'b1);
      end
      run_sweep($urandom_range(1, DEPTH), 1'b0, 0, 1'b0);
      abort = 1'b1;
      tick();
      abort = 1'b0;
      k = $urandom_range(1, DEPTH);
      run_sweep(k, 1'b0, k, 1'b0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/trigger_sweep_sequencer.md
# trigger_sweep_sequencer

Controller that drives the trigger delay datapath through a programmed table of (coarse, fine) delay pairs, one entry per trigger shot. It loads each entry into the coarse and fine delay stages and waits for the fine-delay MMCM to settle. Only then does it enable the trigger path for one shot, and it advances on each delayed trigger output. It sits between the host register block and the delay datapath, and is the sole source of the datapath's coarse/fine update strobes.

## Interface
Parameters:
- DEPTH, 16: table entries (power of two, 2..256)
- SETTLE_CYCLES, 64: consecutive cycles of mmcm_locked=1 required before arming
- LOCK_TIMEOUT, 65536: maximum cycles in SETTLE before fault
- ADDR_W, $clog2(DEPTH): table address width

Ports:
- clk  in  1  system clock
- rst  in  1  reset; asynchronous, active-high
- tbl_we  in  1  table write strobe
- tbl_addr  in  ADDR_W  table write address
- tbl_coarse  in  32  coarse delay, cycles
- tbl_fine  in  16  fine delay, ps
- tbl_len  in  ADDR_W+1  entries used in the sweep, 1..DEPTH
- loop_en  in  1  wrap to entry 0 after the last entry instead of finishing
- arm  in  1  start pulse
- abort  in  1  stop pulse
- trig_fired  in  1  delayed trigger output of the datapath; rising edge detected internally
- mmcm_locked  in  1  fine-delay MMCM lock
- coarse_delay  out  32  to datapath
- coarse_update  out  1  one-cycle strobe
- fine_delay_ps  out  16  to datapath
- fine_update  out  1  one-cycle strobe
- trig_enable  out  1  gates the trigger input of the datapath
- busy  out  1  state not IDLE/DONE/FAULT
- done  out  1  sweep completed
- fault  out  1  error latched
- fault_code  out  2  0 none, 1 bad tbl_len, 2 lock timeout
- cur_index  out  ADDR_W  entry currently loaded
- shot_count  out  32  shots fired since arm, saturating

All outputs reset to 0.

## Operation
- States: IDLE, LOAD, SETTLE, ARMED, ADVANCE, DONE, FAULT.
- Table writes are accepted only in IDLE, DONE or FAULT. Writes in any other state are dropped.
- IDLE/DONE/FAULT + arm:
  - tbl_len valid: go to LOAD; clear cur_index, shot_count, done, fault, fault_code.
  - tbl_len==0 or >DEPTH: go to FAULT with fault_code=1.
- arm in any other state is ignored.
- LOAD (1 cycle):
  - Register coarse_delay and fine_delay_ps from entry cur_index, with fine saturated to 9999.
  - Assert coarse_update and fine_update in the same cycle as the new values.
  - Go to SETTLE.
- SETTLE:
  - A counter counts consecutive cycles with mmcm_locked=1 and resets to 0 on any low cycle.
  - Counter reaching SETTLE_CYCLES: go to ARMED.
  - Total SETTLE time reaching LOCK_TIMEOUT cycles: go to FAULT with fault_code=2.
- ARMED:
  - trig_enable=1.
  - trig_fired rising edge: shot_count+1 (saturating at 2^32-1), go to ADVANCE.
- ADVANCE (1 cycle):
  - cur_index==tbl_len-1 and loop_en=0: go to DONE, done=1.
  - Otherwise cur_index advances (wrapping to 0 after tbl_len-1) and the state goes to LOAD.
- abort in any state: go to IDLE next cycle; trig_enable=0. coarse/fine outputs hold. abort beats arm when both arrive in the same cycle.
- tbl_len and loop_en are sampled live. Changing them mid-sweep is undefined for software but must not hang: the index comparison uses >= to terminate.
- Reset mid-operation returns to IDLE with all outputs 0. Table contents are not reset.

## Timing
- arm at cycle N: LOAD at N+1, update strobes high at N+1, SETTLE from N+2.
- With mmcm_locked held high, ARMED (trig_enable=1) is reached at N+2+SETTLE_CYCLES.
- trig_fired edge sampled at cycle M: trig_enable=0 from M+1, ADVANCE at M+1, next LOAD at M+2.
- Edge detector uses a 1-cycle registered previous value. trig_fired is synchronous to clk.
- A trig_fired edge outside ARMED is ignored. The edge history still updates, so a level already high on entry to ARMED does not count.
- Table read: registered read address, data used in LOAD; cur_index is stable for at least one cycle before LOAD.

## Structure
- Package trigger_seq_pkg: state enum, FINE_MAX_PS=9999, fault-code localparams, table entry struct (coarse 32, fine 16).
- Sub-module trigger_seq_table: DEPTH x 48-bit register file, one write port and one read port, no reset on storage.

## Test plan
- DEPTH=4, table {(10,0),(20,2500),(30,9999),(40,12000)}, tbl_len=4, loop_en=0, lock high, four trig_fired pulses -> coarse_delay sequence 10/20/30/40, fine 0/2500/9999/9999 (saturated), four strobe pairs, shot_count=4, done=1, busy=0.
- arm with lock high -> trig_enable rises exactly SETTLE_CYCLES+2 cycles after arm. Lock dropped for one cycle mid-settle -> arming is delayed by a full SETTLE_CYCLES restart.
- mmcm_locked held low -> fault=1, fault_code=2 after LOCK_TIMEOUT cycles in SETTLE; trig_enable never asserted.
- tbl_len=0 at arm -> FAULT next cycle, fault_code=1. Rearm after tbl_len=2 -> clears fault, sweep runs.
- loop_en=1, tbl_len=2, five shots -> cur_index 0,1,0,1,0, shot_count=5, done stays 0. abort -> IDLE next cycle, trig_enable=0.
- tbl_we during ARMED -> entry unchanged on the next lap. Async rst mid-SETTLE -> all outputs 0 immediately, state IDLE.
